// File: rtl/fc_engine.sv
// Multi-cycle fully-connected layer engine: one signed MAC per cycle per output
// neuron, then arithmetic shift, ReLU and saturation into a packed 8-bit result.
module fc_engine #(
    parameter int FC_BITWIDTH    = 8,
    parameter int FC_INPUT_SIZE  = 4,
    parameter int FC_OUTPUT_SIZE = 2,
    parameter int ACC_WIDTH      = 20,
    parameter int OUT_SHIFT      = 7
) (
    input  logic                                                clk_i,
    input  logic                                                reset,
    input  logic                                                start_i,
    input  logic [31:0]                                         input_vec_i,
    input  logic [31:0]                                         bias_i,
    input  logic [FC_BITWIDTH*FC_INPUT_SIZE*FC_OUTPUT_SIZE-1:0] weight_matrix_i,
    output logic                                                busy_o,
    output logic                                                done_o,
    output logic [31:0]                                         result_o,
    output logic [3:0]                                          is_pos_o
);

    localparam int ROW_BITS = FC_BITWIDTH * FC_INPUT_SIZE;
    localparam int MAT_W    = ROW_BITS * FC_OUTPUT_SIZE;
    localparam int COL_W    = (FC_INPUT_SIZE  > 1) ? $clog2(FC_INPUT_SIZE)  : 1;
    localparam int ROW_W    = (FC_OUTPUT_SIZE > 1) ? $clog2(FC_OUTPUT_SIZE) : 1;

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(FC_INPUT_SIZE - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(FC_OUTPUT_SIZE - 1);
    localparam logic signed [ACC_WIDTH-1:0] Y_MAX = ACC_WIDTH'((2 ** (FC_BITWIDTH - 1)) - 1);

    typedef logic [FC_BITWIDTH-1:0] elem_t;
    typedef enum logic [1:0] {S_IDLE, S_MAC, S_STORE, S_DONE} state_t;

    state_t state_q, state_d;

    elem_t [FC_INPUT_SIZE-1:0]                     x_in, x_q;
    elem_t [FC_OUTPUT_SIZE-1:0]                    b_in, b_q;
    elem_t [FC_OUTPUT_SIZE-1:0][FC_INPUT_SIZE-1:0] w_in, w_q;

    logic signed [ACC_WIDTH-1:0]     acc_q;
    logic [COL_W-1:0]                col_q;
    logic [ROW_W-1:0]                row_q;
    elem_t [FC_OUTPUT_SIZE-1:0]      res_q;
    logic [FC_OUTPUT_SIZE-1:0]       pos_q;
    logic                            done_q;

    logic signed [2*FC_BITWIDTH-1:0] prod;
    logic signed [ACC_WIDTH-1:0]     y;
    elem_t                           out_val;
    logic                            unused_bits;

    // Bus unpacking: element 0 always sits in the most significant byte.
    for (genvar j = 0; j < FC_INPUT_SIZE; j++) begin : g_x
        assign x_in[j] = input_vec_i[31-FC_BITWIDTH*j -: FC_BITWIDTH];
    end
    for (genvar n = 0; n < FC_OUTPUT_SIZE; n++) begin : g_row
        assign b_in[n] = bias_i[31-FC_BITWIDTH*n -: FC_BITWIDTH];
        for (genvar j = 0; j < FC_INPUT_SIZE; j++) begin : g_w
            assign w_in[n][j] = weight_matrix_i[MAT_W-1-ROW_BITS*n-FC_BITWIDTH*j -: FC_BITWIDTH];
        end
        assign result_o[31-FC_BITWIDTH*n -: FC_BITWIDTH] = res_q[n];
        assign is_pos_o[3-n]                             = pos_q[n];
    end
    if (FC_OUTPUT_SIZE * FC_BITWIDTH < 32) begin : g_res_pad
        assign result_o[31-FC_OUTPUT_SIZE*FC_BITWIDTH:0] = '0;
    end
    if (FC_OUTPUT_SIZE < 4) begin : g_pos_pad
        assign is_pos_o[3-FC_OUTPUT_SIZE:0] = '0;
    end

    assign unused_bits = ^{input_vec_i, bias_i};

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values; blocking here would create order-dependent simulation.
    always_ff @(posedge clk_i) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start_i) state_d = S_MAC;
            S_MAC:   if (col_q == COL_LAST) state_d = S_STORE;
            S_STORE: state_d = (row_q == ROW_LAST) ? S_DONE : S_MAC;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy_o = (state_q != S_IDLE);
        done_o = done_q;
    end

    always_comb begin
        prod    = $signed(x_q[col_q]) * $signed(w_q[row_q][col_q]);
        y       = acc_q >>> OUT_SHIFT;
        out_val = y[FC_BITWIDTH-1:0];
        if (y[ACC_WIDTH-1])  out_val = '0;
        else if (y > Y_MAX)  out_val = Y_MAX[FC_BITWIDTH-1:0];
    end

    // NOTE: operand copies are plain data storage gated by the accepted start,
    // so they carry no reset; only control state and visible outputs are reset.
    always_ff @(posedge clk_i) begin
        if (state_q == S_IDLE && start_i) begin
            x_q <= x_in;
            b_q <= b_in;
            w_q <= w_in;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset) begin
            acc_q  <= '0;
            col_q  <= '0;
            row_q  <= '0;
            res_q  <= '0;
            pos_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= (state_q == S_DONE);
            unique case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        acc_q <= ACC_WIDTH'($signed(b_in[0]));
                        col_q <= '0;
                        row_q <= '0;
                        res_q <= '0;
                        pos_q <= '0;
                    end
                end
                S_MAC: begin
                    acc_q <= acc_q + ACC_WIDTH'(prod);
                    if (col_q != COL_LAST) col_q <= col_q + 1'b1;
                end
                S_STORE: begin
                    res_q[row_q] <= out_val;
                    pos_q[row_q] <= (out_val != '0);
                    if (row_q != ROW_LAST) begin
                        row_q <= row_q + 1'b1;
                        col_q <= '0;
                        acc_q <= ACC_WIDTH'($signed(b_q[row_q + 1'b1]));
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/fc_engine.md
Name: fc_engine

Overview:
- Multi-cycle fully-connected (FC) layer execution unit.
- Sits directly downstream of the register file and consumes its packed weight-matrix output (registers 25/26), with the input vector from the RS read port and biases from the RT read port.
- Computes one MAC per cycle and returns a packed 8-bit ReLU result plus per-output positivity tags. These are written back as RDdata/is_pos by the writeback stage.

Parameters:
- FC_BITWIDTH, 8, element width of inputs, weights, biases and outputs (signed two's complement).
- FC_INPUT_SIZE, 4, input vector length.
- FC_OUTPUT_SIZE, 2, number of output neurons; FC_OUTPUT_SIZE*FC_BITWIDTH <= 32.
- ACC_WIDTH, 20, signed accumulator width.
- OUT_SHIFT, 7, arithmetic right shift applied to the accumulator before clamping (Q1.7 weights).

Ports:
- clk_i, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- start_i, input, 1, request to begin an FC operation; sampled only in IDLE.
- input_vec_i, input, 32, input vector; element j = bits [31-8j -: 8].
- bias_i, input, 32, biases; bias n = bits [31-8n -: 8]; unused low bytes ignored.
- weight_matrix_i, input, FC_BITWIDTH*FC_INPUT_SIZE*FC_OUTPUT_SIZE, weights; row n = bits [63-32n -: 32] (row 0 = reg25); element j within a row = MSB byte first.
- busy_o, output, 1, high from the cycle after start is accepted until done_o.
- done_o, output, 1, one-cycle pulse when result_o/is_pos_o are final.
- result_o, output, 32, output n in bits [31-8n -: 8]; unused bytes 0.
- is_pos_o, output, 4, bit [3-n] = 1 iff output n > 0; unused bits 0.

Behaviour:
- Reset (synchronous, active-high): state=IDLE; busy_o=0, done_o=0, result_o=0, is_pos_o=0; accumulator, row and column counters cleared.
  - Reset mid-operation aborts immediately with no done_o.
  - Reset dominates start_i in the same cycle.
- IDLE, start_i=1:
  - Latch input_vec_i, bias_i and weight_matrix_i into internal copies; later changes at the inputs are ignored until the next start.
  - acc <= sign-extended bias 0; row=0, col=0; clear result_o and is_pos_o; go to MAC.
- MAC:
  - acc <= acc + sext(w[row][col]) * sext(x[col]), signed product.
  - If col==FC_INPUT_SIZE-1, go to STORE; else col++.
- STORE:
  - y = acc >>> OUT_SHIFT.
  - out = 0 if y<0; 127 if y>127; else y[7:0].
  - Write out into result_o byte row; is_pos_o[3-row] = (out != 0).
  - If row==FC_OUTPUT_SIZE-1, go to DONE; else row++, col=0, acc <= sext(bias[row+1]), go to MAC.
- DONE: done_o=1 for exactly one cycle, then go to IDLE.
- result_o/is_pos_o hold their values after DONE until the next accepted start or reset.
- Latency: start sampled at edge T puts done_o high in the cycle after edge T + FC_OUTPUT_SIZE*(FC_INPUT_SIZE+1) + 1 (T+11 at defaults). busy_o is high for all MAC/STORE cycles.
- start_i while busy or in DONE is ignored (not queued). start_i held high continuously relaunches in the IDLE cycle after DONE.
- Arithmetic:
  - The accumulator never wraps at defaults: worst-case |sum| = 4*128*128 + 128 < 2^19.
  - Saturation applies only in STORE.

Test Plan:
- Nominal (FC preset values):
  - Stimulus: input_vec_i=0x0753320C, bias_i=0xFF7F0000, weights {0x1743030F, 0x08785B1F}, start pulse.
  - Response: acc0=6051 → 0x2F, acc1=15065 → 0x75; result_o=0x2F750000, is_pos_o=4'b1100, done_o exactly 11 cycles after start.
- Saturation:
  - Stimulus: all input bytes 0x7F, all weights 0x7F, bias_i=0x7F7F0000.
  - Response: acc=64643 → clamp; result_o=0x7F7F0000, is_pos_o=4'b1100.
- ReLU/negative:
  - Stimulus: input 0x7F7F7F7F, row 0 weights 0xFFFFFFFF, row 1 weights 0x01010101, bias_i=0xFF000000.
  - Response: acc0=-509 → 0, acc1=508 → 3; result_o=0x00030000, is_pos_o=4'b0100.
- Operand latching:
  - Stimulus: start with the nominal values, then change all inputs to 0 on the next cycle.
  - Response: result identical to the nominal case.
- Start while busy:
  - Stimulus: pulse start_i at cycles 3 and 10 after the first start.
  - Response: single done_o at T+11, no second operation.
  - Follow-up: start_i held high yields back-to-back results with done_o every 12 cycles.
- Reset mid-operation:
  - Stimulus: assert reset at cycle 5 of an operation.
  - Response: next cycle busy_o=0, result_o=0, is_pos_o=0, no done_o. A subsequent start completes normally with correct values.
